shift_row_stage: RTL and testbench

SHIFT_ROW_STAGE -- requirements
Module: shift_row_stage

---
 rtl/shift_row_stage_pkg.sv | 24 ++
 rtl/shift_row_map.sv | 17 +
 rtl/shift_row_stage.sv | 84 ++++++++
 tb/tb_shift_row_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_row_stage_pkg.sv
// Shared AES definitions for the ShiftRows stage: state width, byte permutation
// tables and the buffer occupancy type.
package shift_row_stage_pkg;

    localparam int STATE_W     = 128;
    localparam int STATE_BYTES = STATE_W / 8;

    // Entry k (bits [4k+3:4k]) is the input byte index that feeds output byte k.
    localparam logic [63:0] FWD_TABLE = {4'd11, 4'd6, 4'd1, 4'd12, 4'd7, 4'd2, 4'd13, 4'd8,
                                         4'd3, 4'd14, 4'd9, 4'd4, 4'd15, 4'd10, 4'd5, 4'd0};
    localparam logic [63:0] INV_TABLE = {4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd2, 4'd5, 4'd8,
                                         4'd11, 4'd14, 4'd1, 4'd4, 4'd7, 4'd10, 4'd13, 4'd0};

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    function automatic logic [3:0] srcByte(input int k, input logic inverse);
        return inverse ? INV_TABLE[4*k +: 4] : FWD_TABLE[4*k +: 4];
    endfunction

endpackage

// File: rtl/shift_row_map.sv
// Combinational ShiftRows / InvShiftRows byte permutation of one AES state word.
module shift_row_map
    import shift_row_stage_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    input  logic               inverse,
    output logic [STATE_W-1:0] mapped
);

    always_comb begin
        mapped = '0;
        for (int k = 0; k < STATE_BYTES; k++) begin
            mapped[8*k +: 8] = state[8*srcByte(k, inverse) +: 8];
        end
    end

endmodule

// File: rtl/shift_row_stage.sv
// ShiftRows pipeline stage with a two-entry (main + skid) valid/ready buffer.
// Define SHIFT_ROW_INV_EN to add the per-word in_inverse select.
module shift_row_stage
    import shift_row_stage_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
`ifdef SHIFT_ROW_INV_EN
    input  logic               in_inverse,
`endif
    input  logic [STATE_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic [CNT_W-1:0]   beat_count
);

    logic [STATE_W-1:0] mappedData;
    logic [STATE_W-1:0] skidData;
    logic               inverseSel;
    logic               inXfer;
    logic               outXfer;
    occ_t               occupancy;
    occ_t               nextOcc;

`ifdef SHIFT_ROW_INV_EN
    assign inverseSel = in_inverse;
`else
    assign inverseSel = 1'b0;
`endif

    // Words are permuted on the way in, so buffered entries are already final.
    shift_row_map uMap (
        .state   (in_data),
        .inverse (inverseSel),
        .mapped  (mappedData)
    );

    assign inXfer  = in_valid && in_ready;
    assign outXfer = out_valid && out_ready;

    always_comb begin
        nextOcc = occupancy;
        case (occupancy)
            OCC_EMPTY: if (inXfer) nextOcc = OCC_ONE;
            OCC_ONE: begin
                if (inXfer && !outXfer)      nextOcc = OCC_TWO;
                else if (!inXfer && outXfer) nextOcc = OCC_EMPTY;
            end
            OCC_TWO:   if (outXfer) nextOcc = OCC_ONE;
            default:   nextOcc = OCC_EMPTY;
        endcase
    end

    // A draining skid word always reaches main before any new word is stored.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            occupancy  <= OCC_EMPTY;
            out_valid  <= 1'b0;
            in_ready   <= 1'b0;
            out_data   <= '0;
            skidData   <= '0;
            beat_count <= '0;
        end else begin
            occupancy <= nextOcc;
            out_valid <= (nextOcc != OCC_EMPTY);
            in_ready  <= (nextOcc != OCC_TWO);
            if (outXfer)
                beat_count <= beat_count + CNT_W'(1);
            if (occupancy == OCC_TWO && outXfer)
                out_data <= skidData;
            else if (inXfer && (occupancy == OCC_EMPTY || outXfer))
                out_data <= mappedData;
            if (inXfer && occupancy == OCC_ONE && !outXfer)
                skidData <= mappedData;
        end
    end

endmodule

// File: tb/tb_shift_row_stage.sv
// Directed bench for shift_row_stage (counter width 4 so the wrap is reachable).
module tb_shift_row_stage;
    import shift_row_stage_pkg::*;

    localparam int CNT_W = 4;

    logic               clock;
    logic               reset_n;
    logic               inValid;
    logic               inReady;
    logic               inInverse;
    logic [STATE_W-1:0] inData;
    logic               outValid;
    logic               outReady;
    logic [STATE_W-1:0] outData;
    logic [CNT_W-1:0]   beatCount;

    int compared;
    int mismatched;

    logic [STATE_W-1:0] wordA, wordB, wordC, fwdVec, fwdExp;

    shift_row_stage #(.CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (inValid),
        .in_ready   (inReady),
`ifdef SHIFT_ROW_INV_EN
        .in_inverse (inInverse),
`endif
        .in_data    (inData),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_data   (outData),
        .beat_count (beatCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Independent model: output byte 4c+r from input byte 4((c+/-r) mod 4)+r.
    function automatic logic [STATE_W-1:0] refShift(input logic [STATE_W-1:0] s, input logic inv);
        logic [STATE_W-1:0] res;
        int srcCol;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                srcCol = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
                res[8*(4*c+r) +: 8] = s[8*(4*srcCol+r) +: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [STATE_W-1:0] wordFor(input int i);
        return {32'(i * 7 + 1), 32'(i) ^ 32'hdeadbeef, 32'(i * i), 32'(i) ^ 32'h5a5a0f0f};
    endfunction

    task automatic checkOutput(input string tag, input logic [STATE_W-1:0] got,
                               input logic [STATE_W-1:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [STATE_W-1:0] data,
                                 input logic ready, input logic inv);
        inValid   = valid;
        inData    = data;
        outReady  = ready;
        inInverse = inv;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);

        // Asynchronous reset, checked before any clock edge.
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rstValid", outValid, 1'b0);
        checkOutput("rstReady", inReady, 1'b0);
        checkOutput("rstData", outData, '0);
        checkOutput("rstCount", beatCount, '0);
        tick();
        checkOutput("rstReadyHeld", inReady, 1'b0);
        reset_n = 1'b1;
        tick();
        checkOutput("readyAfterRelease", inReady, 1'b1);

        // Forward mapping on the reference vector.
        fwdVec = 128'h0f0e0d0c0b0a09080706050403020100;
        fwdExp = 128'h0b06010c07020d08030e09040f0a0500;
        applyStimulus(1'b1, fwdVec, 1'b1, 1'b0);
        tick();
        checkOutput("fwdValid", outValid, 1'b1);
        checkOutput("fwdData", outData, fwdExp);
        checkOutput("fwdModel", refShift(fwdVec, 1'b0), fwdExp);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("fwdCount", beatCount, 4'd1);
        checkOutput("fwdDrained", outValid, 1'b0);

        // Backpressure: two words fill main and skid, the third waits upstream.
        doReset();
        wordA = 128'h00112233445566778899aabbccddeeff;
        wordB = 128'hfedcba98765432100123456789abcdef;
        wordC = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        applyStimulus(1'b1, wordA, 1'b0, 1'b0);
        tick();
        checkOutput("bpReady1", inReady, 1'b1);
        applyStimulus(1'b1, wordB, 1'b0, 1'b0);
        tick();
        checkOutput("bpReady2", inReady, 1'b0);
        applyStimulus(1'b1, wordC, 1'b0, 1'b0);
        tick();
        checkOutput("bpHoldValid", outValid, 1'b1);
        checkOutput("bpHoldData", outData, refShift(wordA, 1'b0));
        checkOutput("bpHoldReady", inReady, 1'b0);
        applyStimulus(1'b1, wordC, 1'b1, 1'b0);
        tick();
        checkOutput("bpOutB", outData, refShift(wordB, 1'b0));
        checkOutput("bpCount1", beatCount, 4'd1);
        checkOutput("bpReadyBack", inReady, 1'b1);
        tick();
        checkOutput("bpOutC", outData, refShift(wordC, 1'b0));
        checkOutput("bpCount2", beatCount, 4'd2);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("bpEmpty", outValid, 1'b0);
        checkOutput("bpCount3", beatCount, 4'd3);

        // Streaming 100 back-to-back words; also covers the 4-bit counter wrap.
        doReset();
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, wordFor(i), 1'b1, 1'b0);
            tick();
            checkOutput("streamData", outData, refShift(wordFor(i), 1'b0));
            checkOutput("streamValid", outValid, 1'b1);
            checkOutput("streamReady", inReady, 1'b1);
            if (i == 15) checkOutput("countMax", beatCount, 4'd15);
            if (i == 17) checkOutput("countWrap", beatCount, 4'd1);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("streamDone", outValid, 1'b0);
        checkOutput("streamCount", beatCount, 4'd4);

        // Reset while full: held words must vanish.
        doReset();
        applyStimulus(1'b1, wordA, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("midPreCount", beatCount, 4'd1);
        applyStimulus(1'b1, wordB, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, wordC, 1'b0, 1'b0);
        tick();
        checkOutput("midFull", inReady, 1'b0);
        reset_n = 1'b0;
        #1;
        checkOutput("midRstValid", outValid, 1'b0);
        checkOutput("midRstCount", beatCount, '0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("midNoStale", outValid, 1'b0);
        end
        checkOutput("midCountStill", beatCount, '0);

`ifdef SHIFT_ROW_INV_EN
        // Inverse select on the forward result restores the original state.
        doReset();
        applyStimulus(1'b1, fwdExp, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, wordA, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("invData", outData, fwdVec);
        tick();
        checkOutput("invThenFwd", outData, refShift(wordA, 1'b0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
